// File: rtl/fetch_ctrl_pkg.sv
// Shared IF-stage control definitions: FSM state encoding and the
// one-hot {JR,J,Z} PC-source select codes. ID control and the PC mux use these too.
package fetch_ctrl_pkg;

  typedef logic [2:0] pc_sel_t;

  // FSM state encoding (legacy-compatible constants)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  // PC mux select, one-hot {JR,J,Z}; all-zero selects PC+4
  localparam pc_sel_t PC_SEL_NEXT = 3'b000;
  localparam pc_sel_t PC_SEL_BR   = 3'b001;
  localparam pc_sel_t PC_SEL_J    = 3'b010;
  localparam pc_sel_t PC_SEL_JR   = 3'b100;

  // Resolve simultaneous redirect requests: jr > jump > branch_taken
  function automatic pc_sel_t redirect_sel(input logic jr, input logic jump,
                                           input logic branch_taken);
    pc_sel_t sel;
    sel = PC_SEL_NEXT;
    if (jr)                sel = PC_SEL_JR;
    else if (jump)         sel = PC_SEL_J;
    else if (branch_taken) sel = PC_SEL_BR;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive cycles spent waiting on the instruction memory.
// expired pulses on the wait cycle that brings the count to TIMEOUT_CYC.
module fetch_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_reg;

  // Wait-cycle counter; clear dominates increment
  always_ff @(posedge clk) begin
    if (reset || clr) count_reg <= '0;
    else if (inc)     count_reg <= count_reg + 1'b1;
  end

  assign expired = inc & ~clr & (count_reg == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage control FSM: PC source select, PC / IF-ID enables, fetch handshake
// with a multi-cycle instruction memory, redirect abort and wait-timeout retry.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  output logic             mem_req,
  input  logic             mem_ready,
  output logic [2:0]       pc_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             fetch_valid,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [1:0] state_reg, state_next;
  logic       mem_timeout_reg;
  logic       redir;
  logic       fetching;
  logic       timer_expired;

  // A stalled ID stage re-presents its redirect later, so stall masks it here
  assign redir    = ~stall & (jr | jump | branch_taken);
  assign fetching = (state_reg == S_FETCH);
  assign mem_req  = fetching;

  // Wait timer runs only while an issued request is outstanding
  fetch_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (~fetching | mem_ready | redir),
    .inc     (fetching & ~mem_ready),
    .expired (timer_expired)
  );

  // Datapath strobes; a redirect flushes IF/ID and discards any returning word
  always_comb begin
    pc_sel      = PC_SEL_NEXT;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    fetch_valid = 1'b0;
    if (!reset) begin
      if (redir) begin
        pc_sel     = redirect_sel(jr, jump, branch_taken);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else if (fetching && mem_ready && !stall) begin
        fetch_valid = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    end
  end

  // Abort only when a request is still in flight (redirect without data, or timeout)
  always_comb begin
    state_next = S_FETCH;
    if (fetching && ((redir && !mem_ready) || timer_expired))
      state_next = S_ABORT;
  end

  // State register and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (timer_expired) mem_timeout_reg <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, redirect_cnt_reg;

  // Free-running wrap-around perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
    end else begin
      if (stall && fetching) stall_cnt_reg    <= stall_cnt_reg + 1'b1;
      if (redir)             redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt    = stall_cnt_reg;
  assign redirect_cnt = redirect_cnt_reg;
`else
  assign stall_cnt    = '0;
  assign redirect_cnt = '0;
`endif

endmodule
